// File: rtl/uart_rx_param_if.sv
// Receiver-side signal bundle: serial line and enable in, received word,
// strobe, error flags and busy out. The receiver uses the master modport.
interface uart_rx_param_if #(
    parameter int DataBits = 8
);
    logic                En;
    logic                Rx;
    logic [DataBits-1:0] RxData;
    logic                RxDataValid;
    logic                ParityError;
    logic                FramingError;
    logic                Busy;

    modport master (
        input  En,
        input  Rx,
        output RxData,
        output RxDataValid,
        output ParityError,
        output FramingError,
        output Busy
    );

    modport slave (
        output En,
        output Rx,
        input  RxData,
        input  RxDataValid,
        input  ParityError,
        input  FramingError,
        input  Busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority
// vote, 5..9 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Completed frames (errored or not) are delivered with a one-cycle strobe.
module uart_rx_param #(
    parameter int ClocksPerBit = 10417,
    parameter int DataBits     = 8,
    parameter int ParityMode   = 0,
    parameter int StopBits     = 1,
    parameter int CntW         = $clog2(ClocksPerBit)
) (
    input  logic             Clk,
    input  logic             Rst,
    uart_rx_param_if.master  bus
);
    localparam int Half = (ClocksPerBit - 1) / 2;
    localparam int IdxW = (DataBits > 1) ? $clog2(DataBits) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClocksPerBit - 1);
    localparam logic [CntW-1:0] CntS0   = CntW'(Half - 1);
    localparam logic [CntW-1:0] CntS1   = CntW'(Half);
    localparam logic [CntW-1:0] CntDec  = CntW'(Half + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);
    localparam logic            StopLast = 1'(StopBits - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_meta_d;
    logic                rx_s_q, rx_s_d;
    logic                armed_q, armed_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                stop_idx_q, stop_idx_d;
    logic [1:0]          samp_q, samp_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_out_q, perr_out_d;
    logic                ferr_out_q, ferr_out_d;
    logic                busy_q, busy_d;

    logic vote;
    logic at_dec;
    logic at_last;
    logic par_exp;

    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign at_dec  = (cnt_q == CntDec);
    assign at_last = (cnt_q == CntLast);
    assign par_exp = (ParityMode == 2) ? (^shift_q) : ~(^shift_q);

    // Next-state logic: synchroniser, sample capture, frame sequencing.
    always_comb begin
        state_d    = state_q;
        rx_meta_d  = bus.Rx;
        rx_s_d     = rx_meta_q;
        // After a framing error the line must be seen high before re-arming,
        // so a held break yields one frame rather than a stream of them.
        armed_d    = armed_q | rx_s_q;
        cnt_d      = cnt_q + CntW'(1);
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;

        if (cnt_q == CntS0) samp_d[0] = rx_s_q;
        if (cnt_q == CntS1) samp_d[1] = rx_s_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q && armed_q) state_d = S_START;
            end
            S_START: begin
                if (at_dec && vote) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                for (int i = 0; i < DataBits; i++) begin
                    if (at_dec && idx_q == IdxW'(i)) shift_d[i] = vote;
                end
                if (at_last) begin
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
                        state_d    = (ParityMode != 0) ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_dec && (vote != par_exp)) perr_d = 1'b1;
                if (at_last) begin
                    state_d    = S_STOP;
                    cnt_d      = '0;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (at_dec) begin
                    if (!vote) ferr_d = 1'b1;
                    // Leave at mid-bit of the last stop bit so the next start
                    // edge can be caught without waiting out the bit.
                    if (stop_idx_q == StopLast) begin
                        state_d    = S_DONE;
                        data_d     = shift_q;
                        valid_d    = 1'b1;
                        perr_out_d = perr_q;
                        ferr_out_d = ferr_q | ~vote;
                    end
                end else if (at_last) begin
                    cnt_d      = '0;
                    stop_idx_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                if (ferr_q) armed_d = rx_s_q;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Disable abandons any frame without a strobe; held outputs persist.
        if (!bus.En) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            data_d     = data_q;
            valid_d    = 1'b0;
            perr_out_d = perr_out_q;
            ferr_out_d = ferr_out_q;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State register with synchronous reset; synchroniser resets to idle-high.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            armed_q    <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.RxData       = data_q;
    assign bus.RxDataValid  = valid_q;
    assign bus.ParityError  = perr_out_q;
    assign bus.FramingError = ferr_out_q;
    assign bus.Busy         = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1, 8E1, 7O2) at
// 16 clocks per bit. Stimulus pushes expected frames; a monitor pops and
// compares on every RxDataValid strobe.
module tb_uart_rx_param;
    localparam int Cpb = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_drv [3];
    logic en_drv [3];

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    uart_rx_param_if #(.DataBits(8)) if_a ();
    uart_rx_param_if #(.DataBits(8)) if_b ();
    uart_rx_param_if #(.DataBits(7)) if_c ();

    assign if_a.Rx = rx_drv[0];
    assign if_b.Rx = rx_drv[1];
    assign if_c.Rx = rx_drv[2];
    assign if_a.En = en_drv[0];
    assign if_b.En = en_drv[1];
    assign if_c.En = en_drv[2];

    uart_rx_param #(.ClocksPerBit(Cpb), .DataBits(8), .ParityMode(0), .StopBits(1))
        dut_a (.Clk(clk), .Rst(rst), .bus(if_a));
    uart_rx_param #(.ClocksPerBit(Cpb), .DataBits(8), .ParityMode(2), .StopBits(1))
        dut_b (.Clk(clk), .Rst(rst), .bus(if_b));
    uart_rx_param #(.ClocksPerBit(Cpb), .DataBits(7), .ParityMode(1), .StopBits(2))
        dut_c (.Clk(clk), .Rst(rst), .bus(if_c));

    logic       valid_w [3];
    logic [8:0] data_w  [3];
    logic       pe_w    [3];
    logic       fe_w    [3];
    logic       busy_w  [3];

    assign valid_w[0] = if_a.RxDataValid;
    assign valid_w[1] = if_b.RxDataValid;
    assign valid_w[2] = if_c.RxDataValid;
    assign data_w[0]  = {1'b0, if_a.RxData};
    assign data_w[1]  = {1'b0, if_b.RxData};
    assign data_w[2]  = {2'b00, if_c.RxData};
    assign pe_w[0]    = if_a.ParityError;
    assign pe_w[1]    = if_b.ParityError;
    assign pe_w[2]    = if_c.ParityError;
    assign fe_w[0]    = if_a.FramingError;
    assign fe_w[1]    = if_b.FramingError;
    assign fe_w[2]    = if_c.FramingError;
    assign busy_w[0]  = if_a.Busy;
    assign busy_w[1]  = if_b.Busy;
    assign busy_w[2]  = if_c.Busy;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input int inst, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        case (inst)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: pop one expected frame per strobe and compare.
    task automatic check_strobe(input int inst);
        exp_t e;
        int sz;
        case (inst)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe inst=%0d actual=%h required=none", inst, data_w[inst]);
        end else begin
            case (inst)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("rxdata[%0d]", inst), data_w[inst], e.d);
            chk($sformatf("parity_err[%0d]", inst), {8'b0, pe_w[inst]}, {8'b0, e.pe});
            chk($sformatf("framing_err[%0d]", inst), {8'b0, fe_w[inst]}, {8'b0, e.fe});
            chk($sformatf("busy_at_done[%0d]", inst), {8'b0, busy_w[inst]}, 9'd0);
            $display("frame inst=%0d data=%h pe=%0b fe=%0b", inst, data_w[inst], pe_w[inst], fe_w[inst]);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid_w[k]) check_strobe(k);
        end
    end

    // One bit period on the chosen line; optional 1-cycle inverted glitch at mid-bit.
    task automatic drive_bit(input int inst, input logic v, input bit glitch);
        rx_drv[inst] = v;
        if (glitch) begin
            repeat (8) @(posedge clk);
            rx_drv[inst] = ~v;
            @(posedge clk);
            rx_drv[inst] = v;
            repeat (Cpb - 9) @(posedge clk);
        end else begin
            repeat (Cpb) @(posedge clk);
        end
    endtask

    task automatic send_frame(input int inst, input logic [8:0] d, input int nd,
                              input bit has_par, input logic pbit, input int nstop,
                              input logic stopv, input int glitch_at);
        int n;
        n = 0;
        drive_bit(inst, 1'b0, n == glitch_at); n++;
        for (int i = 0; i < nd; i++) begin
            drive_bit(inst, d[i], n == glitch_at); n++;
        end
        if (has_par) begin
            drive_bit(inst, pbit, n == glitch_at); n++;
        end
        for (int s = 0; s < nstop; s++) begin
            drive_bit(inst, stopv, n == glitch_at); n++;
        end
        rx_drv[inst] = 1'b1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
    endtask

    task automatic chk_outputs_a(input string tag, input logic [8:0] d, input logic busy);
        chk({tag, "_data"}, data_w[0], d);
        chk({tag, "_valid"}, {8'b0, valid_w[0]}, 9'd0);
        chk({tag, "_pe"}, {8'b0, pe_w[0]}, 9'd0);
        chk({tag, "_fe"}, {8'b0, fe_w[0]}, 9'd0);
        chk({tag, "_busy"}, {8'b0, busy_w[0]}, {8'b0, busy});
    endtask

    initial begin
        logic [8:0] w;
        for (int k = 0; k < 3; k++) begin
            rx_drv[k] = 1'b1;
            en_drv[k] = 1'b1;
        end
        rst = 1'b1;
        idle(4);
        @(negedge clk);
        chk_outputs_a("reset", 9'h000, 1'b0);
        rst = 1'b0;
        idle(10);

        // 8N1 clean frame
        push_exp(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(20);

        // 8E1: correct parity, then wrong parity
        push_exp(1, 9'h003, 1'b0, 1'b0);
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1, -1);
        idle(20);
        push_exp(1, 9'h003, 1'b1, 1'b0);
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1, -1);
        idle(20);

        // 8N1: bad stop bit, then a clean frame clears the flag
        push_exp(0, 9'h05A, 1'b0, 1'b1);
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0, -1);
        idle(20);
        push_exp(0, 9'h03C, 1'b0, 1'b0);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(20);

        // False start: 3-cycle low glitch on idle line
        rx_drv[0] = 1'b0;
        idle(3);
        rx_drv[0] = 1'b1;
        idle(1);
        @(negedge clk);
        chk("false_start_busy_hi", {8'b0, busy_w[0]}, 9'd1);
        idle(20);
        @(negedge clk);
        chk("false_start_busy_lo", {8'b0, busy_w[0]}, 9'd0);

        // Mid-bit glitch inside data bit 3 is voted out
        push_exp(0, 9'h0FF, 1'b0, 1'b0);
        send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 4);
        idle(20);

        // 7O2 back-to-back frames
        push_exp(2, 9'h041, 1'b0, 1'b0);
        send_frame(2, 9'h041, 7, 1'b1, 1'b1, 2, 1'b1, -1);
        push_exp(2, 9'h02A, 1'b0, 1'b0);
        send_frame(2, 9'h02A, 7, 1'b1, 1'b0, 2, 1'b1, -1);
        idle(20);

        // Reset during data bit 4 abandons the frame
        w = 9'h081;
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, w[i], 1'b0);
        rx_drv[0] = w[4];
        idle(5);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        rx_drv[0] = 1'b1;
        @(negedge clk);
        chk_outputs_a("mid_reset", 9'h000, 1'b0);
        idle(30);
        push_exp(0, 9'h081, 1'b0, 1'b0);
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(20);

        // Disable mid-frame: no strobe, held word unchanged
        w = 9'h077;
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, w[i], 1'b0);
        en_drv[0] = 1'b0;
        idle(2);
        rx_drv[0] = 1'b1;
        idle(5);
        en_drv[0] = 1'b1;
        idle(30);
        @(negedge clk);
        chk("en_off_data_held", data_w[0], 9'h081);
        chk("en_off_busy", {8'b0, busy_w[0]}, 9'd0);
        push_exp(0, 9'h077, 1'b0, 1'b0);
        send_frame(0, 9'h077, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(50);

        // Any frame still queued never produced a strobe
        @(negedge clk);
        chk("leftover_q0", 9'(q0.size()), 9'd0);
        chk("leftover_q1", 9'(q1.size()), 9'd0);
        chk("leftover_q2", 9'(q2.size()), 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
